// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl: power-up, command wait and SPI read-frame sequencer for the PMOD serial ADC
// Ports: i_clock/i_reset (sync, active low) | i_enable, i_start commands | i_adc_sdata serial in
//        o_adc_cs_n, o_adc_sclk SPI drive (CPOL=1) | o_data, o_data_valid last good sample
//        o_init_done, o_idle, o_wait_cmd status levels | o_error, o_succes per-frame pulses
module adc_sample_ctrl #(
    parameter int CLK_DIV      = 4,
    parameter int INIT_CYCLES  = 16,
    parameter int QUIET_CYCLES = 8,
    parameter int DATA_BITS    = 12
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_start,
    input  logic                 i_adc_sdata,
    output logic                 o_adc_cs_n,
    output logic                 o_adc_sclk,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_valid,
    output logic                 o_init_done,
    output logic                 o_idle,
    output logic                 o_wait_cmd,
    output logic                 o_error,
    output logic                 o_succes
);
    localparam int FRAME   = DATA_BITS + 4;
    localparam int M1      = (INIT_CYCLES > 2 * CLK_DIV) ? INIT_CYCLES : 2 * CLK_DIV;
    localparam int CNT_MAX = (M1 > QUIET_CYCLES) ? M1 : QUIET_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(FRAME + 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WAIT, S_CONV, S_DONE} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [BW-1:0]    bit_cnt, bit_cnt_d;
    logic [FRAME-1:0] shreg;
    logic             rise, period_end, frame_end, good;

    assign rise       = state == S_CONV && cnt == CW'(CLK_DIV - 1);
    assign period_end = state == S_CONV && cnt == CW'(2 * CLK_DIV - 1);
    assign frame_end  = state == S_CONV && state_d == S_DONE;
    assign good       = shreg[FRAME-1 -: 4] == 4'd0;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_cnt_d = bit_cnt;
        case (state)
            S_INIT: begin
                cnt_d   = o_init_done ? cnt : cnt + CW'(1);
                state_d = !o_init_done ? S_INIT : i_enable ? S_WAIT : S_IDLE;
            end
            S_IDLE: state_d = i_enable ? S_WAIT : S_IDLE;
            S_WAIT: begin
                state_d   = !i_enable ? S_IDLE : i_start ? S_CONV : S_WAIT;
                bit_cnt_d = '0;
            end
            S_CONV: begin
                cnt_d     = period_end ? '0 : cnt + CW'(1);
                bit_cnt_d = period_end ? bit_cnt + BW'(1) : bit_cnt;
                state_d   = (period_end && bit_cnt == BW'(FRAME - 1)) ? S_DONE : S_CONV;
            end
            S_DONE: begin
                cnt_d   = cnt + CW'(1);
                state_d = cnt != CW'(QUIET_CYCLES - 1) ? S_DONE : i_enable ? S_WAIT : S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
        // every state starts its own count from zero
        if (state_d != state) cnt_d = '0;
    end

    // outputs are registered from the next-state decode so cs_n/sclk never glitch
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state        <= S_INIT;
            cnt          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            o_adc_cs_n   <= 1'b1;
            o_adc_sclk   <= 1'b1;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_init_done  <= 1'b0;
            o_idle       <= 1'b0;
            o_wait_cmd   <= 1'b0;
            o_error      <= 1'b0;
            o_succes     <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            bit_cnt      <= bit_cnt_d;
            if (rise) shreg <= {shreg[FRAME-2:0], i_adc_sdata};
            o_adc_cs_n   <= state_d != S_CONV;
            o_adc_sclk   <= !(state_d == S_CONV && cnt_d < CW'(CLK_DIV));
            o_idle       <= state_d == S_IDLE;
            o_wait_cmd   <= state_d == S_WAIT;
            if (state == S_INIT && cnt == CW'(INIT_CYCLES - 1)) o_init_done <= 1'b1;
            o_data_valid <= frame_end && good;
            o_succes     <= frame_end && good;
            o_error      <= frame_end && !good;
            if (frame_end && good) o_data <= shreg[DATA_BITS-1:0];
        end
    end
endmodule
